wb_mem_arbiter_2m: RTL and testbench
====================================

// Module: wb_mem_arbiter_2m
// PURPOSE
//  Shares the single Wishbone memory-master port between two requesters:
//  M0 = wb_ppfifo_2_mem camera writer, M1 = host/DMA reader. Round-robin with
//  a whole-cycle lock, plus a per-transfer ack watchdog so a stuck slave
//  cannot hang either requester. Sits between the masters and the memory
//  interconnect.
// PARAMETERS
//  ADDR_WIDTH  32  address width of all adr ports
//  DATA_WIDTH  32  data width of all dat ports; sel width = DATA_WIDTH/8
//  TIMEOUT     1024  stb-without-ack cycles before abort; 0 = watchdog off
// PORTS
//  clk                 in   1     system clock
//  rst                 in   1     asynchronous, active-high reset
//  m0_i_we/stb/cyc     in   1     M0 Wishbone write enable / strobe / cycle
//  m0_i_sel            in   DW/8  M0 byte selects
//  m0_i_adr            in   AW    M0 address
//  m0_i_dat            in   DW    M0 write data
//  m0_o_dat            out  DW    M0 read data
//  m0_o_ack            out  1     M0 ack
//  m0_o_err            out  1     M0 watchdog abort, one-cycle pulse
//  m0_o_int            out  1     copy of s_i_int
//  m1_*                --   --    identical set for M1
//  s_o_we/stb/cyc      out  1     to memory slave
//  s_o_sel             out  DW/8  to memory slave
//  s_o_adr             out  AW    to memory slave
//  s_o_dat             out  DW    to memory slave
//  s_i_dat             in   DW    from memory slave
//  s_i_ack             in   1     from memory slave
//  s_i_int             in   1     from memory slave
//  o_owner             out  2     00 idle, 01 M0, 10 M1, 11 abort-drain
//  o_timeout_count     out  16    saturating count of watchdog aborts
// BEHAVIOUR
//  - Reset (async): state IDLE, last_grant=M1 (M0 wins first tie), watchdog=0,
//    o_timeout_count=0. All s_o_*, mN_o_ack, mN_o_err, mN_o_dat = 0.
//    o_owner=00. Takes effect immediately, including mid-transfer.
//  - Request: reqN = mN_i_cyc.
//  - States: IDLE, GNT0, GNT1, DRAIN. The state is registered. Output muxing
//    is combinational from the state.
//  - IDLE: s_o_* = 0.
//    - req0&req1: go to GNT of the master != last_grant.
//    - Single request: go to GNT of that master.
//    - Grant latency: 1 clk from cyc rise to the slave seeing the master.
//  - GNTn: s_o_* = mn_i_*.
//    - mn_o_ack = s_i_ack, mn_o_dat = s_i_dat.
//    - Non-owner: ack = 0, dat = 0, its request is held pending.
//    - mn_i_cyc low: go to IDLE, last_grant <= n. Always one idle cycle
//      between owners; no direct handoff.
//  - Watchdog (TIMEOUT>0, GNTn only):
//    - Counter clears when s_i_ack, ~s_o_stb, or on state change.
//    - Otherwise it increments.
//    - At count == TIMEOUT-1 with no ack: mn_o_err=1 for that cycle, next
//      state DRAIN, o_timeout_count += 1 (saturates at 16'hFFFF).
//    - An ack in the same cycle as expiry wins: no err, counter clears.
//  - DRAIN: s_o_* forced 0, acks 0. Stay until the aborted master's cyc is
//    low, then go to IDLE with last_grant = aborted master.
//  - mN_o_int = s_i_int for both masters, always, ungated.
//  - Burst/pipelined cycles: the lock holds across any number of stb/ack
//    beats while cyc stays high.
//  - Width rule: sel is DW/8 bits; no address or data modification.
// TESTING
//  - Reset, then M0 write adr 0x100, dat 0xA5A5A5A5:
//    - s_o_stb rises 1 clk after m0_i_cyc.
//    - m0_o_ack follows s_i_ack.
//    - o_owner = 01, then 00 after cyc drops.
//  - M0 and M1 cyc rise in the same cycle after reset:
//    - M0 is granted first; M1 is granted after one IDLE cycle.
//    - Repeat: M1 is then granted first (alternation).
//  - M1 holds cyc for 8 beats while M0 requests:
//    - M0 gets no ack and never reaches the slave until M1 drops cyc.
//    - Ownership never changes mid-burst.
//  - TIMEOUT=16, slave never acks M0:
//    - m0_o_err pulses on stb cycle 16.
//    - s_o_stb = 0 from the next cycle.
//    - o_owner = 11 until m0 cyc drops.
//    - o_timeout_count = 1.
//  - Ack arrives on exactly cycle 16: no err, count stays 0.
//  - Assert rst during a GNT1 transfer:
//    - s_o_* and acks go 0 asynchronously.
//    - After release, a tie grants M0.

Source files
------------

// File: rtl/wb_mem_arbiter_2m_if.sv
// ----------------------------------------------------------------------------
// wb_mem_arbiter_2m_if
//   One Wishbone link: a requester on one side and a responder on the other.
//   Used three times around the arbiter: M0 link, M1 link and memory link.
//
//   Signals
//     cyc, stb, we   master -> slave   cycle / strobe / write enable
//     sel            master -> slave   byte selects (DW/8 bits)
//     adr            master -> slave   address (AW bits)
//     dat_w          master -> slave   write data (DW bits)
//     dat_r          slave  -> master  read data (DW bits)
//     ack            slave  -> master  transfer acknowledge
//     err            slave  -> master  abort pulse
//     irq            slave  -> master  interrupt
//
//   Modports
//     master : the side that issues cycles
//     slave  : the side that answers them
// ----------------------------------------------------------------------------
interface wb_mem_arbiter_2m_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;
    logic            irq;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err, irq
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err, irq
    );
endinterface

// File: rtl/wb_mem_arbiter_2m.sv
// ----------------------------------------------------------------------------
// wb_mem_arbiter_2m
//   Two-master Wishbone arbiter in front of a single memory port.
//   M0 = camera writer, M1 = host/DMA reader. Round-robin on ties, the
//   grant is locked for the whole cyc, and a per-transfer ack watchdog
//   aborts a stuck transfer into a drain state.
//
//   Ports
//     clk              in   system clock
//     rst              in   asynchronous, active-high reset
//     m0               slave modport   link from requester M0
//     m1               slave modport   link from requester M1
//     s                master modport  link to the memory slave
//     o_owner          out  00 idle, 01 M0, 10 M1, 11 abort-drain
//     o_timeout_count  out  saturating count of watchdog aborts
// ----------------------------------------------------------------------------
module wb_mem_arbiter_2m #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_mem_arbiter_2m_if.slave    m0,
    wb_mem_arbiter_2m_if.slave    m1,
    wb_mem_arbiter_2m_if.master   s,
    output logic [1:0]            o_owner,
    output logic [15:0]           o_timeout_count
);
    localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StDrain} state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;     // 0 = M0 granted last, 1 = M1
    logic           abort_q, abort_d;   // master that was aborted into drain
    logic [WdW-1:0] wd_q, wd_d;
    logic [15:0]    tcnt_q, tcnt_d;

    logic granted, own_cyc, own_stb, expire;

    assign granted = (state_q == StGnt0) || (state_q == StGnt1);
    assign own_cyc = (state_q == StGnt0) ? m0.cyc : m1.cyc;
    assign own_stb = (state_q == StGnt0) ? m0.stb : m1.stb;

    // An ack in the expiry cycle wins over the abort.
    assign expire = (TIMEOUT != 0) && granted && own_cyc && own_stb && !s.ack &&
                    (wd_q == WdMax);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            abort_q <= 1'b0;
            wd_q    <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            abort_q <= abort_d;
            wd_q    <= wd_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        abort_d = abort_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            StIdle: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0.cyc) begin
                    state_d = StGnt0;
                end else if (m1.cyc) begin
                    state_d = StGnt1;
                end
            end
            StGnt0, StGnt1: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                    last_d  = (state_q == StGnt1);
                end else if (expire) begin
                    state_d = StDrain;
                    abort_d = (state_q == StGnt1);
                    if (tcnt_q != 16'hFFFF) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            StDrain: begin
                if (!(abort_q ? m1.cyc : m0.cyc)) begin
                    state_d = StIdle;
                    last_d  = abort_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Watchdog restarts on every ack, idle strobe or ownership change.
        wd_d = '0;
        if (granted && (state_d == state_q) && own_stb && !s.ack) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Output muxing, purely from the registered state
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.sel   = '0;
        s.adr   = '0;
        s.dat_w = '0;
        m0.ack  = 1'b0;
        m0.dat_r = '0;
        m0.err  = 1'b0;
        m1.ack  = 1'b0;
        m1.dat_r = '0;
        m1.err  = 1'b0;
        o_owner = 2'b00;
        case (state_q)
            StGnt0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.sel    = m0.sel;
                s.adr    = m0.adr;
                s.dat_w  = m0.dat_w;
                m0.ack   = s.ack;
                m0.dat_r = s.dat_r;
                m0.err   = expire;
                o_owner  = 2'b01;
            end
            StGnt1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.sel    = m1.sel;
                s.adr    = m1.adr;
                s.dat_w  = m1.dat_w;
                m1.ack   = s.ack;
                m1.dat_r = s.dat_r;
                m1.err   = expire;
                o_owner  = 2'b10;
            end
            StDrain: o_owner = 2'b11;
            default: o_owner = 2'b00;
        endcase
    end

    assign m0.irq          = s.irq;
    assign m1.irq          = s.irq;
    assign o_timeout_count = tcnt_q;
endmodule

// File: tb/tb_wb_mem_arbiter_2m.sv
// ----------------------------------------------------------------------------
// tb_wb_mem_arbiter_2m
//   Directed bench for wb_mem_arbiter_2m with a 16-cycle watchdog.
// ----------------------------------------------------------------------------
module tb_wb_mem_arbiter_2m;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  owner;
    logic [15:0] tcount;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter_2m_if #(.AW(AW), .DW(DW)) m0_if ();
    wb_mem_arbiter_2m_if #(.AW(AW), .DW(DW)) m1_if ();
    wb_mem_arbiter_2m_if #(.AW(AW), .DW(DW)) s_if ();

    wb_mem_arbiter_2m #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m0              (m0_if.slave),
        .m1              (m1_if.slave),
        .s               (s_if.master),
        .o_owner         (owner),
        .o_timeout_count (tcount)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic m0_req(input logic on, input logic [31:0] adr, input logic we);
        m0_if.cyc = on; m0_if.stb = on; m0_if.we = we; m0_if.adr = adr;
    endtask

    task automatic m1_req(input logic on, input logic [31:0] adr, input logic we);
        m1_if.cyc = on; m1_if.stb = on; m1_if.we = we; m1_if.adr = adr;
    endtask

    initial begin
        rst = 1'b1;
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.sel = '0;
        m0_if.adr = '0; m0_if.dat_w = '0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.sel = '0;
        m1_if.adr = '0; m1_if.dat_w = '0;
        s_if.ack = 1'b1; s_if.dat_r = 32'hDEADBEEF; s_if.irq = 1'b0; s_if.err = 1'b0;

        // Reset state: slave ack/data must not leak to either master
        #12;
        chk("rst_owner", owner, 2'b00);
        chk("rst_s_stb", s_if.stb, 1'b0);
        chk("rst_s_cyc", s_if.cyc, 1'b0);
        chk("rst_tcount", tcount, 16'd0);
        chk("rst_m0_ack", m0_if.ack, 1'b0);
        chk("rst_m0_dat", m0_if.dat_r, 32'd0);
        chk("rst_m1_dat", m1_if.dat_r, 32'd0);
        s_if.ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single M0 write
        tick();
        m0_req(1'b1, 32'h100, 1'b1);
        m0_if.dat_w = 32'hA5A5A5A5;
        m0_if.sel = 4'hF;
        #1;
        chk("w_latency_stb", s_if.stb, 1'b0);
        chk("w_latency_owner", owner, 2'b00);
        tick();
        chk("w_owner", owner, 2'b01);
        chk("w_s_stb", s_if.stb, 1'b1);
        chk("w_s_cyc", s_if.cyc, 1'b1);
        chk("w_s_we", s_if.we, 1'b1);
        chk("w_s_adr", s_if.adr, 32'h100);
        chk("w_s_dat", s_if.dat_w, 32'hA5A5A5A5);
        chk("w_s_sel", s_if.sel, 4'hF);
        chk("w_m0_ack_pre", m0_if.ack, 1'b0);
        s_if.ack = 1'b1;
        s_if.dat_r = 32'h12345678;
        #1;
        chk("w_m0_ack", m0_if.ack, 1'b1);
        chk("w_m0_dat", m0_if.dat_r, 32'h12345678);
        chk("w_m1_ack", m1_if.ack, 1'b0);
        chk("w_m1_dat", m1_if.dat_r, 32'd0);
        tick();
        s_if.ack = 1'b0;
        m0_req(1'b0, 32'h0, 1'b0);
        #1;
        chk("w_owner_hold", owner, 2'b01);
        tick();
        chk("w_owner_release", owner, 2'b00);
        chk("w_release_stb", s_if.stb, 1'b0);

        // Tie after M0 was served: M1 first, then M0 after one idle cycle
        m0_req(1'b1, 32'h200, 1'b1);
        m1_req(1'b1, 32'h300, 1'b0);
        tick();
        chk("alt_owner_m1", owner, 2'b10);
        chk("alt_s_adr_m1", s_if.adr, 32'h300);
        chk("alt_s_we_m1", s_if.we, 1'b0);
        s_if.ack = 1'b1;
        #1;
        chk("alt_m0_ack_blocked", m0_if.ack, 1'b0);
        chk("alt_m1_ack", m1_if.ack, 1'b1);
        tick();
        s_if.ack = 1'b0;
        m1_req(1'b0, 32'h0, 1'b0);
        tick();
        chk("alt_idle_gap", owner, 2'b00);
        chk("alt_idle_stb", s_if.stb, 1'b0);
        tick();
        chk("alt_owner_m0", owner, 2'b01);
        chk("alt_s_adr_m0", s_if.adr, 32'h200);
        m0_req(1'b0, 32'h0, 1'b0);
        tick();
        chk("alt_done", owner, 2'b00);

        // Tie straight after reset: M0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req(1'b1, 32'h210, 1'b1);
        m1_req(1'b1, 32'h310, 1'b0);
        tick();
        chk("tie_owner_m0", owner, 2'b01);
        m0_req(1'b0, 32'h0, 1'b0);
        tick();
        chk("tie_idle_gap", owner, 2'b00);
        tick();
        chk("tie_owner_m1", owner, 2'b10);
        m1_req(1'b0, 32'h0, 1'b0);
        tick();
        chk("tie_done", owner, 2'b00);

        // M1 eight-beat burst with M0 pending
        m1_req(1'b1, 32'h400, 1'b0);
        tick();
        chk("burst_owner", owner, 2'b10);
        m0_req(1'b1, 32'h500, 1'b1);
        s_if.ack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            #1;
            chk("burst_lock_owner", owner, 2'b10);
            chk("burst_lock_adr", s_if.adr, 32'h400);
            chk("burst_m0_ack", m0_if.ack, 1'b0);
            chk("burst_m1_ack", m1_if.ack, 1'b1);
            tick();
        end
        s_if.ack = 1'b0;
        m1_req(1'b0, 32'h0, 1'b0);
        tick();
        chk("burst_idle_gap", owner, 2'b00);
        tick();
        chk("burst_m0_granted", owner, 2'b01);
        chk("burst_m0_adr", s_if.adr, 32'h500);

        // Watchdog abort: M0 stb cycle 1 now, slave never acks
        for (int k = 0; k < 14; k++) tick();
        chk("wd_err_c15", m0_if.err, 1'b0);
        tick();
        chk("wd_err_c16", m0_if.err, 1'b1);
        chk("wd_m1_err", m1_if.err, 1'b0);
        chk("wd_owner_c16", owner, 2'b01);
        tick();
        chk("wd_drain_owner", owner, 2'b11);
        chk("wd_drain_stb", s_if.stb, 1'b0);
        chk("wd_drain_cyc", s_if.cyc, 1'b0);
        chk("wd_drain_err", m0_if.err, 1'b0);
        chk("wd_tcount", tcount, 16'd1);
        tick();
        chk("wd_drain_hold", owner, 2'b11);
        m0_req(1'b0, 32'h0, 1'b0);
        tick();
        chk("wd_drain_exit", owner, 2'b00);

        // Ack exactly on stb cycle 16 beats the watchdog
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req(1'b1, 32'h600, 1'b1);
        tick();
        for (int k = 0; k < 14; k++) tick();
        tick();
        s_if.ack = 1'b1;
        #1;
        chk("race_err", m0_if.err, 1'b0);
        chk("race_ack", m0_if.ack, 1'b1);
        tick();
        s_if.ack = 1'b0;
        #1;
        chk("race_owner", owner, 2'b01);
        chk("race_tcount", tcount, 16'd0);
        m0_req(1'b0, 32'h0, 1'b0);
        tick();

        // Interrupt passthrough
        s_if.irq = 1'b1;
        #1;
        chk("irq_m0_hi", m0_if.irq, 1'b1);
        chk("irq_m1_hi", m1_if.irq, 1'b1);
        s_if.irq = 1'b0;
        #1;
        chk("irq_m0_lo", m0_if.irq, 1'b0);

        // Asynchronous reset during a GNT1 transfer
        m1_req(1'b1, 32'h700, 1'b0);
        tick();
        chk("arst_owner_pre", owner, 2'b10);
        s_if.ack = 1'b1;
        #1;
        chk("arst_m1_ack_pre", m1_if.ack, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_s_stb", s_if.stb, 1'b0);
        chk("arst_s_cyc", s_if.cyc, 1'b0);
        chk("arst_s_adr", s_if.adr, 32'h0);
        chk("arst_m1_ack", m1_if.ack, 1'b0);
        chk("arst_owner", owner, 2'b00);
        m0_req(1'b1, 32'h800, 1'b1);
        tick();
        chk("arst_held_idle", owner, 2'b00);
        rst = 1'b0;
        tick();
        chk("arst_tie_m0", owner, 2'b01);
        chk("arst_tie_adr", s_if.adr, 32'h800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
